// File: rtl/sram_req_arbiter_if.sv
// Bundle for the shared-SRAM arbiter: fetch side, data side, shared memory port
// and the sticky protocol-error flag.
interface sram_req_arbiter_if;
  // fetch side
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  // data side
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  // shared memory port
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  // status
  logic        arb_err;

  // arbiter view
  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output arb_err
  );

  // environment view (requesters + memory)
  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  arb_err
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// Two-requester arbiter for one SRAM-like req/addr_ok/data_ok port.
// Data side wins over fetch; a grant is held until addr_ok. An owner-bit FIFO
// steers the in-order completions back to whoever issued each transaction.
module sram_req_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            resetn,
  sram_req_arbiter_if.slave bus
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DHOLD = 2'd1;
  localparam logic [1:0] S_IHOLD = 2'd2;

  logic [1:0]                 r_state;
  logic [1:0]                 w_state_nxt;
  logic [MAX_OUTSTANDING-1:0] r_own;
  logic [PW-1:0]              r_wptr;
  logic [PW-1:0]              r_rptr;
  logic [PW:0]                r_count;
  logic                       r_err;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_head;
  logic w_orphan;

  assign w_full   = (r_count == (PW+1)'(MAX_OUTSTANDING));
  assign w_push   = bus.mem_req & bus.mem_addr_ok;
  // completions with nothing outstanding are protocol errors, never pops
  assign w_pop    = bus.mem_data_ok & (r_count != '0);
  assign w_orphan = bus.mem_data_ok & (r_count == '0);
  assign w_head   = r_own[r_rptr];

  // Grant decision: only IDLE looks at requests, using the registered count,
  // so a pop in a full cycle enables a grant decision one cycle later.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_full) begin
          if (bus.data_req)      w_state_nxt = S_DHOLD;
          else if (bus.inst_req) w_state_nxt = S_IHOLD;
        end
      end
      S_DHOLD, S_IHOLD: begin
        if (bus.mem_addr_ok) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; a held grant is never pre-empted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Owner FIFO: push owner on address handshake, pop on completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_own   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_own[r_wptr] <= (r_state == S_DHOLD);
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error: completion arrived with nothing outstanding.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       r_err <= 1'b0;
    else if (w_orphan) r_err <= 1'b1;
  end

  // Memory-port mux: data payload in D_HOLD, fixed word read of inst_addr otherwise.
  always_comb begin
    bus.mem_req   = (r_state == S_DHOLD) | (r_state == S_IHOLD);
    bus.mem_wr    = 1'b0;
    bus.mem_size  = 2'd2;
    bus.mem_wstrb = 4'b0000;
    bus.mem_addr  = bus.inst_addr;
    bus.mem_wdata = 32'h0;
    if (r_state == S_DHOLD) begin
      bus.mem_wr    = bus.data_wr;
      bus.mem_size  = bus.data_size;
      bus.mem_wstrb = bus.data_wstrb;
      bus.mem_addr  = bus.data_addr;
      bus.mem_wdata = bus.data_wdata;
    end
  end

  assign bus.inst_addr_ok = bus.mem_addr_ok & (r_state == S_IHOLD);
  assign bus.data_addr_ok = bus.mem_addr_ok & (r_state == S_DHOLD);
  assign bus.inst_data_ok = w_pop & ~w_head;
  assign bus.data_data_ok = w_pop &  w_head;
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;
  assign bus.arb_err      = r_err;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter. The bench plays both requesters and the
// memory slave; expected completions go into a scoreboard queue when a request
// is issued and a negedge monitor pops them whenever a *_data_ok appears.
module tb_sram_req_arbiter;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  sram_req_arbiter_if bus ();

  sram_req_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct packed {
    logic        own;   // 1 = data side
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.inst_req    = 1'b0;
    bus.inst_addr   = 32'h0;
    bus.data_req    = 1'b0;
    bus.data_wr     = 1'b0;
    bus.data_size   = 2'd2;
    bus.data_wstrb  = 4'b0000;
    bus.data_addr   = 32'h0;
    bus.data_wdata  = 32'h0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = 32'h0;
  endtask

  task automatic load(input logic [31:0] a);
    bus.data_req   = 1'b1;
    bus.data_wr    = 1'b0;
    bus.data_size  = 2'd2;
    bus.data_wstrb = 4'b0000;
    bus.data_addr  = a;
  endtask

  // Scoreboard monitor: every completion must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (bus.inst_data_ok || bus.data_data_ok) begin
      if (bus.inst_data_ok && bus.data_data_ok) begin
        chk("both_data_ok", 32'd1, 32'd0);
      end else if (sb.size() == 0) begin
        chk("unexpected_data_ok", {30'd0, bus.data_data_ok, bus.inst_data_ok}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_owner", {31'd0, bus.data_data_ok}, {31'd0, e.own});
        if (e.own) chk("sb_data_rdata", bus.data_rdata, e.rdata);
        else       chk("sb_inst_rdata", bus.inst_rdata, e.rdata);
      end
    end
  end

  initial begin
    quiet();
    resetn = 1'b0;

    // ---- reset: outputs held low even with slave strobes active
    bus.inst_req    = 1'b1;
    bus.mem_addr_ok = 1'b1;
    bus.mem_data_ok = 1'b1;
    nxt(); nxt();
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_inst_addr_ok", {31'd0, bus.inst_addr_ok}, 32'd0);
    chk("rst_data_addr_ok", {31'd0, bus.data_addr_ok}, 32'd0);
    chk("rst_arb_err", {31'd0, bus.arb_err}, 32'd0);
    quiet();
    nxt();
    resetn = 1'b1;
    nxt();
    chk("post_rst_arb_err", {31'd0, bus.arb_err}, 32'd0);

    // ---- 1: single fetch
    nxt();                                      // c0
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1c00_0000;
    sb.push_back({1'b0, 32'h0280_0000});
    #1 chk("t1_c0_mem_req", {31'd0, bus.mem_req}, 32'd0);
    nxt();                                      // c1
    chk("t1_c1_mem_req", {31'd0, bus.mem_req}, 32'd1);
    chk("t1_c1_mem_addr", bus.mem_addr, 32'h1c00_0000);
    chk("t1_c1_mem_size", {30'd0, bus.mem_size}, 32'd2);
    chk("t1_c1_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("t1_c1_inst_addr_ok", {31'd0, bus.inst_addr_ok}, 32'd0);
    nxt();                                      // c2
    bus.mem_addr_ok = 1'b1;
    #1 chk("t1_c2_inst_addr_ok", {31'd0, bus.inst_addr_ok}, 32'd1);
    chk("t1_c2_data_addr_ok", {31'd0, bus.data_addr_ok}, 32'd0);
    nxt();                                      // c3
    bus.mem_addr_ok = 1'b0;
    bus.inst_req    = 1'b0;
    #1 chk("t1_c3_mem_req", {31'd0, bus.mem_req}, 32'd0);
    nxt();                                      // c4
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h0280_0000;
    #1 chk("t1_c4_inst_data_ok", {31'd0, bus.inst_data_ok}, 32'd1);
    nxt();
    bus.mem_data_ok = 1'b0;

    // ---- 2: simultaneous requests, data wins; push+pop in the same cycle
    nxt();                                      // c0
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1c00_0004;
    load(32'h0000_1000);
    sb.push_back({1'b1, 32'hdddd_0001});
    sb.push_back({1'b0, 32'h1111_0002});
    nxt();                                      // c1: data granted
    chk("t2_c1_mem_addr", bus.mem_addr, 32'h0000_1000);
    bus.mem_addr_ok = 1'b1;
    #1 chk("t2_c1_data_addr_ok", {31'd0, bus.data_addr_ok}, 32'd1);
    chk("t2_c1_inst_addr_ok", {31'd0, bus.inst_addr_ok}, 32'd0);
    nxt();                                      // c2: IDLE decides fetch
    bus.data_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    #1 chk("t2_c2_mem_req", {31'd0, bus.mem_req}, 32'd0);
    nxt();                                      // c3: fetch accepted, data completes
    chk("t2_c3_mem_addr", bus.mem_addr, 32'h1c00_0004);
    bus.mem_addr_ok = 1'b1;
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'hdddd_0001;
    #1 chk("t2_c3_inst_addr_ok", {31'd0, bus.inst_addr_ok}, 32'd1);
    chk("t2_c3_data_data_ok", {31'd0, bus.data_data_ok}, 32'd1);
    nxt();                                      // c4: fetch completes
    bus.inst_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_rdata   = 32'h1111_0002;
    #1 chk("t2_c4_inst_data_ok", {31'd0, bus.inst_data_ok}, 32'd1);
    nxt();
    bus.mem_data_ok = 1'b0;

    // ---- 3: fetch grant held while slave stalls; data waits
    nxt();                                      // c0
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1c00_0008;
    sb.push_back({1'b0, 32'h3333_0003});
    nxt();                                      // c1
    load(32'h0000_2000);
    sb.push_back({1'b1, 32'h4444_0004});
    for (int k = 0; k < 3; k++) begin           // c1..c3 addr_ok low
      #1 chk("t3_hold_mem_addr", bus.mem_addr, 32'h1c00_0008);
      chk("t3_hold_data_addr_ok", {31'd0, bus.data_addr_ok}, 32'd0);
      if (k < 2) nxt();
    end
    nxt();                                      // c4
    bus.mem_addr_ok = 1'b1;
    #1 chk("t3_c4_inst_addr_ok", {31'd0, bus.inst_addr_ok}, 32'd1);
    chk("t3_c4_mem_addr", bus.mem_addr, 32'h1c00_0008);
    nxt();                                      // c5
    bus.inst_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    #1 chk("t3_c5_mem_req", {31'd0, bus.mem_req}, 32'd0);
    nxt();                                      // c6: data granted
    chk("t3_c6_mem_addr", bus.mem_addr, 32'h0000_2000);
    bus.mem_addr_ok = 1'b1;
    #1 chk("t3_c6_data_addr_ok", {31'd0, bus.data_addr_ok}, 32'd1);
    nxt();                                      // c7
    bus.data_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h3333_0003;
    nxt();                                      // c8
    bus.mem_rdata   = 32'h4444_0004;
    nxt();
    bus.mem_data_ok = 1'b0;

    // ---- 4: FIFO full blocks the third grant until a completion
    nxt();                                      // c0
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1c00_000c;
    sb.push_back({1'b0, 32'haaaa_000a});
    nxt();                                      // c1
    bus.mem_addr_ok = 1'b1;
    nxt();                                      // c2
    bus.inst_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    load(32'h0000_3000);
    sb.push_back({1'b1, 32'hbbbb_000b});
    nxt();                                      // c3
    bus.mem_addr_ok = 1'b1;
    #1 chk("t4_c3_data_addr_ok", {31'd0, bus.data_addr_ok}, 32'd1);
    nxt();                                      // c4: two outstanding
    bus.mem_addr_ok = 1'b0;
    load(32'h0000_3004);
    sb.push_back({1'b1, 32'hcccc_000c});
    #1 chk("t4_c4_mem_req", {31'd0, bus.mem_req}, 32'd0);
    nxt();                                      // c5
    chk("t4_c5_mem_req", {31'd0, bus.mem_req}, 32'd0);
    nxt();                                      // c6: first completion
    chk("t4_c6_mem_req", {31'd0, bus.mem_req}, 32'd0);
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'haaaa_000a;
    nxt();                                      // c7: grant decision
    bus.mem_data_ok = 1'b0;
    #1 chk("t4_c7_mem_req", {31'd0, bus.mem_req}, 32'd0);
    nxt();                                      // c8
    chk("t4_c8_mem_req", {31'd0, bus.mem_req}, 32'd1);
    chk("t4_c8_mem_addr", bus.mem_addr, 32'h0000_3004);
    bus.mem_addr_ok = 1'b1;
    nxt();                                      // c9
    bus.data_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'hbbbb_000b;
    nxt();                                      // c10
    bus.mem_rdata   = 32'hcccc_000c;
    nxt();
    bus.mem_data_ok = 1'b0;

    // ---- 5: byte store
    nxt();
    bus.data_req   = 1'b1;
    bus.data_wr    = 1'b1;
    bus.data_size  = 2'd0;
    bus.data_wstrb = 4'b0100;
    bus.data_addr  = 32'h0000_4002;
    bus.data_wdata = 32'h00ab_0000;
    sb.push_back({1'b1, 32'h0000_0000});
    nxt();
    chk("t5_mem_wr", {31'd0, bus.mem_wr}, 32'd1);
    chk("t5_mem_size", {30'd0, bus.mem_size}, 32'd0);
    chk("t5_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'h4);
    chk("t5_mem_wdata", bus.mem_wdata, 32'h00ab_0000);
    chk("t5_mem_addr", bus.mem_addr, 32'h0000_4002);
    bus.mem_addr_ok = 1'b1;
    nxt();
    quiet();
    bus.mem_data_ok = 1'b1;
    #1 chk("t5_data_data_ok", {31'd0, bus.data_data_ok}, 32'd1);
    nxt();
    bus.mem_data_ok = 1'b0;

    // ---- 6: orphan completion, then reset mid-transaction
    nxt();
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h0000_0bad;
    #1 chk("t6_orphan_inst_data_ok", {31'd0, bus.inst_data_ok}, 32'd0);
    chk("t6_orphan_data_data_ok", {31'd0, bus.data_data_ok}, 32'd0);
    nxt();
    bus.mem_data_ok = 1'b0;
    #1 chk("t6_arb_err_set", {31'd0, bus.arb_err}, 32'd1);
    nxt(); nxt();
    chk("t6_arb_err_sticky", {31'd0, bus.arb_err}, 32'd1);

    nxt();                                      // c0
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1c00_0010;
    nxt();                                      // c1
    bus.mem_addr_ok = 1'b1;
    nxt();                                      // c2: one outstanding (discarded by reset)
    bus.inst_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    load(32'h0000_5000);
    nxt();                                      // c3: D_HOLD
    chk("t6_pre_rst_mem_req", {31'd0, bus.mem_req}, 32'd1);
    resetn          = 1'b0;
    bus.mem_addr_ok = 1'b1;
    #1 chk("t6_rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("t6_rst_data_addr_ok", {31'd0, bus.data_addr_ok}, 32'd0);
    chk("t6_rst_arb_err", {31'd0, bus.arb_err}, 32'd0);
    quiet();
    nxt();
    resetn = 1'b1;
    nxt();                                      // late completion: FIFO was cleared
    bus.mem_data_ok = 1'b1;
    #1 chk("t6_late_inst_data_ok", {31'd0, bus.inst_data_ok}, 32'd0);
    chk("t6_late_data_data_ok", {31'd0, bus.data_data_ok}, 32'd0);
    nxt();
    bus.mem_data_ok = 1'b0;
    #1 chk("t6_late_arb_err", {31'd0, bus.arb_err}, 32'd1);

    nxt(); nxt();
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
